mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_calc.sv | 40 ++++
 rtl/mdu.sv | 92 +++++++++
 tb/tb_mdu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings and multi-cycle latencies.
// The decoder and hazard unit import the same package.
package mdu_pkg;
  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return is_mul(op) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: returns {hi,lo} and a divide-by-zero flag.
// Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);
  logic        sgn;
  logic [31:0] ua, ub, uq, ur, q, r;

  always_comb begin
    sgn = (op == OP_DIV);
    ua  = (sgn && a[31]) ? (~a + 32'd1) : a;
    ub  = (sgn && b[31]) ? (~b + 32'd1) : b;
    // Substitute a divisor of 1 on zero so the divider never sees 0.
    if (ub == 32'd0) ub = 32'd1;
    uq  = ua / ub;
    ur  = ua % ub;
    q   = (sgn && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
    r   = (sgn && a[31]) ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    res  = 64'd0;
    div0 = 1'b0;
    case (op)
      OP_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV, OP_DIVU: begin
        res  = {r, q};
        div0 = (b == 32'd0);
      end
      default: res = 64'd0;
    endcase
  end
endmodule

// File: rtl/mdu.sv
// MIPS-style HI/LO multiply-divide unit: result computed at issue, committed to
// HI/LO after a fixed 5/10-cycle busy window.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        div0_q, div0_d;
  logic [63:0] calc_res;
  logic        calc_div0;

  mdu_calc u_calc (
    .op   (MDUOp_E),
    .a    (A),
    .b    (B),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    res_d  = res_q;
    div0_d = div0_q;
    if (state_q == ST_RUN) begin
      // Everything on the E-stage inputs is ignored while running.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !div0_q) begin
        hi_d = res_q[63:32];
        lo_d = res_q[31:0];
      end
    end else if (start) begin
      if (is_muldiv(MDUOp_E)) begin
        res_d  = calc_res;
        div0_d = calc_div0;
        cnt_d  = is_mul(MDUOp_E) ? MULT_CYCLES : DIV_CYCLES;
      end
    end else if (MDUOp_E == OP_MTHI) begin
      hi_d = A;
    end else if (MDUOp_E == OP_MTLO) begin
      lo_d = A;
    end
    state_d = (cnt_d != 4'd0) ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    case (MDUOp_E)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus random ops against an
// arithmetic reference model of HI/LO.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUOp_E;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] MDUOut, HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp_E(MDUOp_E),
    .A(A), .B(B), .busy(busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    start = 1'b0; MDUOp_E = OP_NONE; A = 32'd0; B = 32'd0;
  endtask

  // Reference: 64-bit integer arithmetic straight from the ISA definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      OP_DIVU:  if (b != 0) begin hi = a % b; lo = a / b; end
      default: ;
    endcase
  endtask

  // Issue one mult/div and follow it through its busy window; with meddle set,
  // also throw start/mtlo/mthi/mflo at it mid-flight.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit meddle);
    logic [31:0] nh, nl;
    int lat;
    nh = m_hi; nl = m_lo;
    model(op, a, b, nh, nl);
    lat = is_mul(op) ? 5 : 10;
    start = 1'b1; MDUOp_E = op; A = a; B = b;
    cyc();
    idle_in();
    for (int i = 1; i <= lat; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_hold", HI, m_hi);
      chk("lo_hold", LO, m_lo);
      idle_in();
      if (meddle) begin
        if (i == 2) begin start = 1'b1; MDUOp_E = OP_MTLO; A = 32'hAA; end
        else if (i == 3) begin start = 1'b1; MDUOp_E = OP_DIV; A = $urandom; B = $urandom | 32'd1; end
        else if (i == 4) begin MDUOp_E = OP_MTHI; A = 32'h55; end
        else if (i == 5) begin MDUOp_E = OP_MFLO; #1 chk("mflo_run", MDUOut, m_lo); end
      end
      cyc();
    end
    idle_in();
    m_hi = nh; m_lo = nl;
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_new", HI, m_hi);
    chk("lo_new", LO, m_lo);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    MDUOp_E = op; A = v; start = 1'b0;
    cyc();
    idle_in();
    if (op == OP_MTHI) m_hi = v; else m_lo = v;
    chk("mt_hi", HI, m_hi);
    chk("mt_lo", LO, m_lo);
    chk("mt_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    MDUOp_E = OP_MFLO; #1 chk("rst_mflo", MDUOut, 32'd0);
    idle_in();
    reset = 1'b1;

    // First op accepted on the first edge after release.
    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    MDUOp_E = OP_MFHI; #1 chk("mfhi", MDUOut, 32'hFFFFFFFF);
    MDUOp_E = OP_MULT; #1 chk("mdout_other", MDUOut, 32'd0);
    idle_in();

    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'd0);

    mt(OP_MTHI, 32'h1234);
    mt(OP_MTLO, 32'd0);
    run_op(OP_DIV, 32'd77, 32'd0, 1'b0);
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'd0);

    // Mult with disturbances mid-flight; result must come from the mult only.
    run_op(OP_MULTU, 32'hDEADBEEF, 32'h00C0FFEE, 1'b1);

    // start with a non-mult/div op must not launch anything.
    start = 1'b1; MDUOp_E = OP_MTHI; A = 32'h999;
    cyc();
    idle_in();
    chk("bad_start_busy", {31'd0, busy}, 32'd0);
    chk("bad_start_hi", HI, m_hi);

    for (int n = 0; n < 24; n++) begin
      rop = 4'($urandom_range(1, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (rop == OP_MFHI || rop == OP_MFLO) begin
        MDUOp_E = rop; #1
        chk("rnd_mf", MDUOut, (rop == OP_MFHI) ? m_hi : m_lo);
        idle_in();
      end else if (rop == OP_MTHI || rop == OP_MTLO) mt(rop, ra);
      else run_op(rop, ra, rb, n[0]);
    end

    // Reset mid-run at cnt==3 aborts without a late writeback.
    start = 1'b1; MDUOp_E = OP_MULT; A = 32'd123; B = 32'd456;
    cyc();
    idle_in();
    cyc();
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_hi", HI, 32'd0);
      chk("post_lo", LO, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
